mips_multicycle: RTL and testbench

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_mc_pkg.sv | 70 +++++++
 rtl/mips_mc_fsm.sv | 155 +++++++++++++++
 rtl/mips_multicycle.sv | 105 ++++++++++
 tb/tb_mips_multicycle.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS core.
// FSM states, opcode/funct codes, ALU control encoding and the ALU itself.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        SRCB_REG, SRCB_IMM, SRCB_BR
    } srcb_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_inc;
        logic       pc_br;
        logic       pc_jmp;
        logic       ab_we;
        logic       alu_we;
        logic       srca_pc;
        srcb_t      srcb;
        logic [2:0] alu_ctl;
        logic       mdr_we;
        logic       rf_we;
        logic       rf_rd;
        logic       rf_mdr;
        logic       done;
    } ctrl_t;

    function automatic logic [31:0] alu(
        input logic [2:0]  ctl,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] y;
        unique case (ctl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mips_mc_fsm.sv
// Control FSM and instruction decode for the multicycle MIPS core.
// Define MIPS_MULTICYCLE_BNE_EN to decode bne (opcode 6'h05).
module mips_mc_fsm
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] fn,
    input  logic       mem_done,
    input  logic       a_eq_b,
    output ctrl_t      ctrl
);

    state_t     state;
    state_t     next;
    logic [2:0] fn_ctl;
    logic       fn_ok;
    logic       is_mem;
    logic       is_rt;
    logic       is_br;
    logic       is_bne;
    logic       is_addi;
    logic       is_j;

    // Funct field to ALU control; flags unsupported functs
    always_comb begin
        fn_ctl = ALU_ADD;
        fn_ok  = 1'b1;
        unique case (fn)
            FN_ADD:  fn_ctl = ALU_ADD;
            FN_SUB:  fn_ctl = ALU_SUB;
            FN_AND:  fn_ctl = ALU_AND;
            FN_OR:   fn_ctl = ALU_OR;
            FN_SLT:  fn_ctl = ALU_SLT;
            default: fn_ok  = 1'b0;
        endcase
    end

    // Opcode class flags, mutually exclusive by construction
    always_comb begin
        is_mem  = (op == OP_LW) || (op == OP_SW);
        is_rt   = (op == OP_RTYPE) && fn_ok;
        is_addi = (op == OP_ADDI);
        is_j    = (op == OP_J);
`ifdef MIPS_MULTICYCLE_BNE_EN
        is_bne  = (op == OP_BNE);
`else
        is_bne  = 1'b0;
`endif
        is_br   = (op == OP_BEQ) || is_bne;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next;
        end
    end

    // Next state and control outputs; memory states hold until done
    always_comb begin
        next         = state;
        ctrl         = '0;
        ctrl.srcb    = SRCB_REG;
        ctrl.alu_ctl = ALU_ADD;
        unique case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_done) begin
                    ctrl.ir_we  = 1'b1;
                    ctrl.pc_inc = 1'b1;
                    next        = DECODE;
                end
            end
            DECODE: begin
                ctrl.ab_we   = 1'b1;
                ctrl.alu_we  = 1'b1;
                ctrl.srca_pc = 1'b1;
                ctrl.srcb    = SRCB_BR;
                unique case (1'b1)
                    is_mem:  next = MEMADR;
                    is_rt:   next = RTYPEEX;
                    is_br:   next = BEQEX;
                    is_addi: next = ADDIEX;
                    is_j:    next = JEX;
                    default: next = FETCH;
                endcase
            end
            MEMADR: begin
                ctrl.alu_we = 1'b1;
                ctrl.srcb   = SRCB_IMM;
                next        = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_done) begin
                    ctrl.mdr_we = 1'b1;
                    next        = MEMWB;
                end
            end
            MEMWB: begin
                ctrl.rf_we  = 1'b1;
                ctrl.rf_mdr = 1'b1;
                ctrl.done   = 1'b1;
                next        = FETCH;
            end
            MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_done) begin
                    ctrl.done = 1'b1;
                    next      = FETCH;
                end
            end
            RTYPEEX: begin
                ctrl.alu_we  = 1'b1;
                ctrl.alu_ctl = fn_ctl;
                next         = RTYPEWB;
            end
            RTYPEWB: begin
                ctrl.rf_we = 1'b1;
                ctrl.rf_rd = 1'b1;
                ctrl.done  = 1'b1;
                next       = FETCH;
            end
            BEQEX: begin
                ctrl.pc_br = a_eq_b ^ is_bne;
                ctrl.done  = 1'b1;
                next       = FETCH;
            end
            ADDIEX: begin
                ctrl.alu_we = 1'b1;
                ctrl.srcb   = SRCB_IMM;
                next        = ADDIWB;
            end
            ADDIWB: begin
                ctrl.rf_we = 1'b1;
                ctrl.done  = 1'b1;
                next       = FETCH;
            end
            JEX: begin
                ctrl.pc_jmp = 1'b1;
                ctrl.done   = 1'b1;
                next        = FETCH;
            end
            default: next = FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: datapath, register file and ALU, one memory port.
// Define MIPS_MULTICYCLE_BNE_EN to add bne support in mips_mc_fsm.
module mips_multicycle
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        instr_done
);

    ctrl_t       ctrl;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluout;
    logic [31:0] mdr;
    logic [31:0] rf [32];
    logic [31:0] imm;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] alu_y;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mem_done;

    assign mem_done = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign imm      = {{16{ir[15]}}, ir[15:0]};
    assign wa       = ctrl.rf_rd ? ir[15:11] : ir[20:16];
    assign wd       = ctrl.rf_mdr ? mdr : aluout;

    // Outputs are gated so nothing is requested while reset is held
    assign mem_req    = ctrl.mem_req & reset;
    assign mem_we     = ctrl.mem_we & reset;
    assign instr_done = ctrl.done & reset;
    assign mem_addr   = ctrl.iord ? aluout : pc;
    assign mem_wdata  = b;

    mips_mc_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .op       (ir[31:26]),
        .fn       (ir[5:0]),
        .mem_done (mem_done),
        .a_eq_b   (a == b),
        .ctrl     (ctrl)
    );

    // ALU operand selection and evaluation
    always_comb begin
        srca = ctrl.srca_pc ? pc : a;
        unique case (ctrl.srcb)
            SRCB_IMM: srcb = imm;
            SRCB_BR:  srcb = {imm[29:0], 2'b00};
            default:  srcb = b;
        endcase
        alu_y = alu(ctrl.alu_ctl, srca, srcb);
    end

    // Architectural pc plus the inter-cycle holding registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            if (ctrl.ir_we)  ir     <= mem_rdata;
            if (ctrl.mdr_we) mdr    <= mem_rdata;
            if (ctrl.alu_we) aluout <= alu_y;
            if (ctrl.ab_we) begin
                a <= rf[ir[25:21]];
                b <= rf[ir[20:16]];
            end
            if (ctrl.pc_inc) begin
                pc <= pc + 32'd4;
            end else if (ctrl.pc_br) begin
                pc <= aluout;
            end else if (ctrl.pc_jmp) begin
                pc <= {pc[31:28], ir[25:0], 2'b00};
            end
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (ctrl.rf_we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle with a behavioural unified memory.
// Expected retire cycles, next-pc values and stores are hand computed.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic        instr_done;

    logic [31:0] mem  [128];
    logic [31:0] prog [128];
    logic        load_req = 1'b0;
    int          cyc;
    int          stall_cycles = 0;
    int          ready_until = 1000000;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          cyc;
        logic [31:0] pcn;
    } de_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } we_t;

    de_t         dq [$];
    we_t         wq [$];
    de_t         de;
    we_t         wev;
    bit          pend = 1'b0;
    logic [31:0] pend_pc;

    always #5 clk = ~clk;

    mips_multicycle #(
        .RESET_PC    (32'h0),
        .MEM_WAIT_EN (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .instr_done (instr_done)
    );

    assign mem_rdata = mem[mem_addr[8:2]];
    assign mem_ready = (cyc >= stall_cycles) && (cyc < ready_until);

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (load_req) mem <= prog;
        else if (reset && mem_req && mem_we && mem_ready)
            mem[mem_addr[8:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ii(input logic [5:0] op, input int rs,
                                       input int rt, input logic [15:0] imm);
        logic [4:0] s;
        logic [4:0] t;
        s = rs[4:0];
        t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] rr(input int rs, input int rt,
                                       input int rd, input logic [5:0] fn);
        logic [4:0] s;
        logic [4:0] t;
        logic [4:0] d;
        s = rs[4:0];
        t = rt[4:0];
        d = rd[4:0];
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] jj(input logic [31:0] tgt);
        return {6'h02, tgt[27:2]};
    endfunction

    task automatic ed(input int c, input logic [31:0] p);
        dq.push_back('{cyc: c, pcn: p});
    endtask

    task automatic ew(input logic [31:0] ad, input logic [31:0] da);
        wq.push_back('{addr: ad, data: da});
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    endtask

    // Monitor: retire events, next pc after each retire, memory writes
    always @(negedge clk) begin
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("next_pc", pc, pend_pc);
                pend = 1'b0;
            end
            if (instr_done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: pc %h cycle %0d",
                             pc, cyc + 1);
                end else begin
                    de = dq.pop_front();
                    chk("done_cycle", 32'(cyc + 1), 32'(de.cyc));
                    pend    = 1'b1;
                    pend_pc = de.pcn;
                end
            end
            if (mem_req && mem_we && mem_ready) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h",
                             mem_addr, mem_wdata);
                end else begin
                    wev = wq.pop_front();
                    chk("wr_addr", mem_addr, wev.addr);
                    chk("wr_data", mem_wdata, wev.data);
                end
            end
        end
    end

    task automatic start_phase(input int stalls, input int rdy_until);
        reset        = 1'b0;
        stall_cycles = stalls;
        ready_until  = rdy_until;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(instr_done), 32'd0);
        chk("rst_pc", pc, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((dq.size() != 0 || wq.size() != 0 || pend) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout: %0d retires, %0d writes outstanding",
                     dq.size(), wq.size());
            dq.delete();
            wq.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Phase A: arithmetic, loads/stores, $0, slt, unknown op, j, beq
        clear_prog();
        prog[0]  = ii(6'h08, 0, 1, 16'd5);
        prog[1]  = ii(6'h08, 0, 2, 16'd7);
        prog[2]  = rr(1, 2, 3, 6'h20);
        prog[3]  = ii(6'h2b, 0, 3, 16'd4);
        prog[4]  = ii(6'h23, 0, 4, 16'd4);
        prog[5]  = ii(6'h2b, 0, 4, 16'd8);
        prog[6]  = ii(6'h08, 0, 0, 16'd9);
        prog[7]  = rr(0, 0, 5, 6'h20);
        prog[8]  = ii(6'h2b, 0, 5, 16'd12);
        prog[9]  = ii(6'h08, 0, 6, 16'hffff);
        prog[10] = ii(6'h08, 0, 7, 16'd1);
        prog[11] = rr(6, 7, 8, 6'h2a);
        prog[12] = ii(6'h2b, 0, 8, 16'd16);
        prog[13] = rr(7, 6, 9, 6'h22);
        prog[14] = rr(9, 8, 10, 6'h25);
        prog[15] = rr(10, 9, 11, 6'h24);
        prog[16] = ii(6'h2b, 0, 9, 16'd20);
        prog[17] = ii(6'h2b, 0, 10, 16'd24);
        prog[18] = ii(6'h2b, 0, 11, 16'd28);
        prog[19] = 32'hfc00_0000;
        prog[20] = jj(32'h60);
        prog[24] = ii(6'h04, 1, 2, 16'd4);
        prog[25] = ii(6'h08, 0, 12, 16'hfffe);
        prog[26] = ii(6'h2b, 0, 12, 16'd32);
        ed(4, 32'h04);   ed(8, 32'h08);   ed(12, 32'h0c);
        ed(16, 32'h10);  ew(32'd4, 32'd12);
        ed(21, 32'h14);  ed(25, 32'h18);  ew(32'd8, 32'd12);
        ed(29, 32'h1c);  ed(33, 32'h20);
        ed(37, 32'h24);  ew(32'd12, 32'd0);
        ed(41, 32'h28);  ed(45, 32'h2c);  ed(49, 32'h30);
        ed(53, 32'h34);  ew(32'd16, 32'd1);
        ed(57, 32'h38);  ed(61, 32'h3c);  ed(65, 32'h40);
        ed(69, 32'h44);  ew(32'd20, 32'd2);
        ed(73, 32'h48);  ew(32'd24, 32'd3);
        ed(77, 32'h4c);  ew(32'd28, 32'd2);
        ed(82, 32'h60);  ed(85, 32'h64);  ed(89, 32'h68);
        ed(93, 32'h6c);  ew(32'd32, 32'hffff_fffe);
        start_phase(0, 1000000);
        run_until_idle(400);

        // Phase B: three fetch wait states, beq taken, j, bne
        clear_prog();
        prog[0]  = ii(6'h08, 0, 1, 16'd3);
        prog[1]  = ii(6'h08, 0, 2, 16'd4);
        prog[2]  = 32'hfc00_0000;
        prog[3]  = 32'hfc00_0000;
        prog[4]  = ii(6'h04, 1, 1, 16'd2);
        prog[7]  = jj(32'h100);
        prog[64] = ii(6'h05, 1, 2, 16'd1);
        prog[65] = ii(6'h2b, 0, 2, 16'h80);
        prog[66] = ii(6'h2b, 0, 1, 16'h84);
        ed(7, 32'h04);   ed(11, 32'h08);
        ed(18, 32'h1c);  ed(21, 32'h100);
`ifdef MIPS_MULTICYCLE_BNE_EN
        ed(24, 32'h108);
        ed(28, 32'h10c); ew(32'h84, 32'd3);
`else
        ed(27, 32'h108); ew(32'h80, 32'd4);
`endif
        start_phase(3, 1000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(mem_req), 32'd1);
            chk("stall_addr", mem_addr, 32'h0);
            chk("stall_pc", pc, 32'h0);
            chk("stall_done", 32'(instr_done), 32'd0);
        end
        run_until_idle(400);

        // Phase C: reset while a store is waiting, then a clean rerun
        clear_prog();
        prog[0] = ii(6'h08, 0, 1, 16'd9);
        prog[1] = ii(6'h2b, 0, 1, 16'h40);
        ed(4, 32'h04);
        start_phase(0, 7);
        run_until_idle(100);
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL timeout: store request never seen");
        end
        @(negedge clk);
        chk("memwr_hold_done", 32'(instr_done), 32'd0);
        chk("memwr_hold_addr", mem_addr, 32'h40);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_pc", pc, 32'h0);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_nowrite", mem[16], 32'h0);
        ed(4, 32'h04);
        ed(8, 32'h08);   ew(32'h40, 32'd9);
        start_phase(0, 1000000);
        run_until_idle(100);
        chk("rerun_store", mem[16], 32'd9);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
